// File: rtl/frame_buf_arbiter_if.sv
// Single-port pixel RAM bus between the frame buffer arbiter (master) and the RAM (slave).
interface frame_buf_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 24
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/frame_buf_arbiter.sv
// Shares one pixel RAM between display scan-out reads (never stalled) and buffered camera
// writes, and ping-pongs two frame banks at display frame start.
module frame_buf_arbiter #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FRAME_PIXELS = 307200
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       rd_vsync,
    input  logic                       rd_req,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       wr_valid,
    input  logic                       wr_sof,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    frame_buf_arbiter_if.master        mem,
    output logic [7:0]                 frame_drop_cnt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

    logic              vsync_prev_q;
    logic              rd_bank_q,     rd_bank_d;
    logic              wr_bank_q,     wr_bank_d;
    logic [ADDR_W-1:0] rd_addr_q,     rd_addr_d;
    logic [ADDR_W-1:0] wr_cnt_q,      wr_cnt_d;
    logic              wr_active_q,   wr_active_d;
    logic              frame_ready_q, frame_ready_d;
    logic [7:0]        frame_drop_cnt_q, frame_drop_cnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];

    logic              vs_fall;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W:0]   mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    assign vs_fall  = ~rd_vsync & vsync_prev_q;
    assign wr_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push     = wr_valid & wr_ready;
    // Drain only on cycles the reader leaves idle, and never on the swap cycle.
    assign pop      = (count_q != '0) & ~rd_req & ~vs_fall;
    assign head     = fifo_q[rptr_q];

    always_comb begin
        rd_bank_d        = rd_bank_q;
        wr_bank_d        = wr_bank_q;
        rd_addr_d        = rd_addr_q;
        wr_cnt_d         = wr_cnt_q;
        wr_active_d      = wr_active_q;
        frame_ready_d    = frame_ready_q;
        frame_drop_cnt_d = frame_drop_cnt_q;
        mem_en_c         = 1'b0;
        mem_we_c         = 1'b0;
        mem_addr_c       = '0;
        mem_wdata_c      = '0;

        if (!rd_vsync) begin
            rd_addr_d = '0;
        end else if (rd_req) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end

        if (vs_fall && frame_ready_q) begin
            rd_bank_d     = ~rd_bank_q;
            frame_ready_d = 1'b0;
        end

        if (rd_req) begin
            mem_en_c   = 1'b1;
            mem_addr_c = {rd_bank_q, rd_addr_q};
        end else if (pop) begin
            if (head[DATA_W]) begin
                // A new frame always targets the bank not being displayed; an unshown ready frame is dropped.
                wr_bank_d   = ~rd_bank_q;
                wr_cnt_d    = ADDR_W'(1);
                wr_active_d = 1'b1;
                if (frame_ready_q) begin
                    frame_ready_d    = 1'b0;
                    frame_drop_cnt_d = frame_drop_cnt_q + 8'd1;
                end
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = {~rd_bank_q, {ADDR_W{1'b0}}};
                mem_wdata_c = head[DATA_W-1:0];
                if (FRAME_PIXELS == 1) begin
                    frame_ready_d = 1'b1;
                    wr_active_d   = 1'b0;
                end
            end else if (wr_active_q) begin
                wr_cnt_d    = wr_cnt_q + ADDR_W'(1);
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = {wr_bank_q, wr_cnt_q};
                mem_wdata_c = head[DATA_W-1:0];
                if (wr_cnt_q == LAST_PIX) begin
                    frame_ready_d = 1'b1;
                    wr_active_d   = 1'b0;
                end
            end
        end
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_prev_q     <= 1'b1;
            rd_bank_q        <= 1'b0;
            wr_bank_q        <= 1'b1;
            rd_addr_q        <= '0;
            wr_cnt_q         <= '0;
            wr_active_q      <= 1'b0;
            frame_ready_q    <= 1'b0;
            frame_drop_cnt_q <= '0;
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
        end else begin
            vsync_prev_q     <= rd_vsync;
            rd_bank_q        <= rd_bank_d;
            wr_bank_q        <= wr_bank_d;
            rd_addr_q        <= rd_addr_d;
            wr_cnt_q         <= wr_cnt_d;
            wr_active_q      <= wr_active_d;
            frame_ready_q    <= frame_ready_d;
            frame_drop_cnt_q <= frame_drop_cnt_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            count_q          <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {wr_sof, wr_data};
        end
    end

    assign mem.mem_en      = rstn & mem_en_c;
    assign mem.mem_we      = rstn & mem_we_c;
    assign mem.mem_addr    = rstn ? mem_addr_c : '0;
    assign mem.mem_wdata   = mem_wdata_c;
    assign rd_data         = mem.mem_rdata;
    assign frame_drop_cnt  = frame_drop_cnt_q;
endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Randomized bench for frame_buf_arbiter: a frame-level reference model predicts every RAM access,
// read pixel, FIFO backpressure and drop count.
module tb_frame_buf_arbiter;
    localparam int unsigned ADDR_W       = 4;
    localparam int unsigned DATA_W       = 24;
    localparam int unsigned FIFO_DEPTH   = 16;
    localparam int unsigned FRAME_PIXELS = 8;
    localparam int          PIX_SPAN     = 1 << ADDR_W;
    localparam int          MEM_WORDS    = 2 * PIX_SPAN;

    logic              clk = 1'b0;
    logic              rstn;
    logic              rd_vsync;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid;
    logic              wr_sof;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [7:0]        frame_drop_cnt;

    frame_buf_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    frame_buf_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_PIXELS(FRAME_PIXELS)
    ) dut (
        .clk(clk), .rstn(rstn), .rd_vsync(rd_vsync), .rd_req(rd_req), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem(mem_bus), .frame_drop_cnt(frame_drop_cnt)
    );

    always #5 clk = ~clk;

    // RAM: never-written words read back as their own address.
    logic [DATA_W-1:0] ram     [MEM_WORDS];
    bit                ram_vld [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_bus.mem_en) begin
            if (mem_bus.mem_we) begin
                ram[mem_bus.mem_addr]     <= mem_bus.mem_wdata;
                ram_vld[mem_bus.mem_addr] <= 1'b1;
            end else begin
                mem_bus.mem_rdata <= ram_vld[mem_bus.mem_addr] ? ram[mem_bus.mem_addr]
                                                               : DATA_W'(mem_bus.mem_addr);
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit                m_prev_vs;
    int                m_rd_bank, m_wr_bank, m_rd_addr, m_wr_cnt, m_drop;
    bit                m_active, m_ready, m_rd_pend;
    logic [DATA_W-1:0] m_rd_exp;
    logic [DATA_W:0]   m_fifo [$];
    logic [DATA_W-1:0] m_store [MEM_WORDS];

    task automatic model_reset();
        m_prev_vs = 1'b1;
        m_rd_bank = 0;
        m_wr_bank = 1;
        m_rd_addr = 0;
        m_wr_cnt  = 0;
        m_drop    = 0;
        m_active  = 1'b0;
        m_ready   = 1'b0;
        m_rd_pend = 1'b0;
        m_fifo.delete();
    endtask

    // One clock: drive inputs, predict and compare outputs at the falling edge, advance the model.
    task automatic step(input logic vs, input logic rq, input logic wv, input logic ws,
                        input logic [DATA_W-1:0] wd);
        bit                vs_fall, pop, e_ready, e_en, e_we;
        int                e_addr, pix;
        logic [DATA_W:0]   head;
        logic [DATA_W-1:0] e_wd;
        rd_vsync = vs;
        rd_req   = rq;
        wr_valid = wv;
        wr_sof   = ws;
        wr_data  = wd;
        @(negedge clk);
        vs_fall = !vs && m_prev_vs;
        e_ready = m_fifo.size() < FIFO_DEPTH;
        pop     = (m_fifo.size() != 0) && !rq && !vs_fall;
        check_eq("wr_ready", 32'(wr_ready), 32'(e_ready));
        check_eq("frame_drop_cnt", 32'(frame_drop_cnt), 32'(m_drop));
        if (m_rd_pend) check_eq("rd_data", 32'(rd_data), 32'(m_rd_exp));
        e_en = 1'b0; e_we = 1'b0; e_addr = 0; e_wd = '0;
        if (rq) begin
            e_en     = 1'b1;
            e_addr   = m_rd_bank * PIX_SPAN + m_rd_addr;
            m_rd_exp = m_store[e_addr];
        end else if (pop) begin
            head = m_fifo.pop_front();
            if (head[DATA_W]) begin
                if (m_ready) begin
                    m_ready = 1'b0;
                    m_drop  = (m_drop + 1) % 256;
                end
                m_wr_bank = 1 - m_rd_bank;
                m_wr_cnt  = 0;
                m_active  = 1'b1;
            end
            if (m_active) begin
                pix    = m_wr_cnt;
                e_en   = 1'b1;
                e_we   = 1'b1;
                e_addr = m_wr_bank * PIX_SPAN + pix;
                e_wd   = head[DATA_W-1:0];
                m_store[e_addr] = e_wd;
                m_wr_cnt = pix + 1;
                if (pix == FRAME_PIXELS - 1) begin
                    m_ready  = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
        if (vs_fall && m_ready) begin
            m_rd_bank = 1 - m_rd_bank;
            m_ready   = 1'b0;
        end
        if (!vs)     m_rd_addr = 0;
        else if (rq) m_rd_addr = (m_rd_addr + 1) % PIX_SPAN;
        m_rd_pend = rq;
        if (wv && e_ready) m_fifo.push_back({ws, wd});
        m_prev_vs = vs;
        check_eq("mem_en", 32'(mem_bus.mem_en), 32'(e_en));
        check_eq("mem_we", 32'(mem_bus.mem_we), 32'(e_we));
        check_eq("mem_addr", 32'(mem_bus.mem_addr), 32'(e_addr));
        if (e_we) check_eq("mem_wdata", 32'(mem_bus.mem_wdata), 32'(e_wd));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] base);
        step(1'b1, 1'b0, 1'b1, 1'b1, base);
        for (int i = 1; i < FRAME_PIXELS; i++) step(1'b1, 1'b0, 1'b1, 1'b0, base + DATA_W'(i));
    endtask

    task automatic read_burst(input int n);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        for (int k = 0; k < MEM_WORDS; k++) m_store[k] = DATA_W'(k);
        model_reset();
        rstn = 1'b0; rd_vsync = 1'b1; rd_req = 1'b0;
        wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0;
        #2;
        check_eq("reset mem_en", 32'(mem_bus.mem_en), 32'd0);
        check_eq("reset wr_ready", 32'(wr_ready), 32'd1);
        check_eq("reset frame_drop_cnt", 32'(frame_drop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Read latency from bank 0
        read_burst(FRAME_PIXELS);

        // Write a frame, trailing beats past the frame end, then swap and read it back
        send_frame(24'hA0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 24'hEE);
        step(1'b1, 1'b0, 1'b1, 1'b0, 24'hEF);
        idle(4);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        read_burst(3);

        // Reads hold off writes; FIFO fills and backpressures, then drains
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, (i == 0), 24'hB00 + DATA_W'(i));
        idle(20);

        // Back-to-back frames with no frame start in between drop one
        send_frame(24'hC0);
        idle(10);
        send_frame(24'hD0);
        idle(10);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        read_burst(FRAME_PIXELS);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
                 1'(($urandom_range(0, 1))), ($urandom_range(0, 11) == 0), DATA_W'($urandom));
        end

        // Reset mid-frame with the FIFO full and a read in flight
        idle(20);
        step(1'b1, 1'b0, 1'b1, 1'b1, 24'hF0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 24'hF1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 24'hF2);
        idle(3);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 24'hF3 + DATA_W'(i));
        rd_req = 1'b1; wr_valid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check_eq("async rst mem_en", 32'(mem_bus.mem_en), 32'd0);
        check_eq("async rst mem_we", 32'(mem_bus.mem_we), 32'd0);
        check_eq("async rst mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check_eq("async rst wr_ready", 32'(wr_ready), 32'd1);
        check_eq("async rst frame_drop_cnt", 32'(frame_drop_cnt), 32'd0);
        rd_req = 1'b0; wr_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // After reset: non-sof beats are discarded and display stays on bank 0
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 24'h55 + DATA_W'(i));
        idle(4);
        read_burst(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
